alu_issue_stage: RTL and testbench

- Producer side of the ALU operand/control interface: the ID/EX pipeline stage that drives A, B and ALU_Control into the ALU.
- Decodes ALUOp plus funct into the 3-bit ALU_Control encoding.
- Selects forwarded operands and registers everything for one cycle.
- Supports stall (hold) and flush (bubble) from the hazard unit.

---
 rtl/alu_issue_stage.sv | 144 ++++++++++++++
 tb/tb_alu_issue_stage.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// ID/EX issue register: decodes ALU_Control, selects forwarded operands, and registers them with stall/flush.
// Optional macro ALU_ISSUE_FWD_EN enables the EX/MEM and MEM/WB forwarding muxes.
module alu_issue_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          stall,
    input  logic          flush,
    input  logic [1:0]    alu_op,
    input  logic [5:0]    funct,
    input  logic          alu_src,
    input  logic [RW-1:0] rs,
    input  logic [RW-1:0] rt,
    input  logic [DW-1:0] rs_data,
    input  logic [DW-1:0] rt_data,
    input  logic [DW-1:0] imm,
    input  logic          ex_mem_regwrite,
    input  logic [RW-1:0] ex_mem_rd,
    input  logic [DW-1:0] ex_mem_result,
    input  logic          mem_wb_regwrite,
    input  logic [RW-1:0] mem_wb_rd,
    input  logic [DW-1:0] mem_wb_result,
    output logic          out_valid,
    output logic [DW-1:0] A,
    output logic [DW-1:0] B,
    output logic [2:0]    ALU_Control,
    output logic [DW-1:0] store_data
);

    typedef enum logic [2:0] {
        ALU_AND = 3'd0,
        ALU_OR  = 3'd1,
        ALU_ADD = 3'd2,
        ALU_SUB = 3'd6,
        ALU_SLT = 3'd7
    } alu_ctrl_e;

    logic          valid_q, valid_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [DW-1:0] sd_q, sd_d;
    alu_ctrl_e     ctrl_q, ctrl_d;

    alu_ctrl_e     ctrl_dec;
    logic [DW-1:0] rs_fwd;
    logic [DW-1:0] rt_fwd;

    always_comb begin
        ctrl_dec = ALU_ADD;
        case (alu_op)
            2'b00: ctrl_dec = ALU_ADD;
            2'b01: ctrl_dec = ALU_SUB;
            2'b11: ctrl_dec = ALU_SLT;
            default: begin
                case (funct)
                    6'b100000: ctrl_dec = ALU_ADD;
                    6'b100010: ctrl_dec = ALU_SUB;
                    6'b100100: ctrl_dec = ALU_AND;
                    6'b100101: ctrl_dec = ALU_OR;
                    6'b101010: ctrl_dec = ALU_SLT;
                    default:   ctrl_dec = ALU_ADD;
                endcase
            end
        endcase
    end

`ifdef ALU_ISSUE_FWD_EN
    // EX/MEM is the younger producer, so it wins; register 0 is hardwired and never forwarded.
    always_comb begin
        rs_fwd = rs_data;
        if (rs != '0 && ex_mem_regwrite && ex_mem_rd == rs) begin
            rs_fwd = ex_mem_result;
        end else if (rs != '0 && mem_wb_regwrite && mem_wb_rd == rs) begin
            rs_fwd = mem_wb_result;
        end
    end

    always_comb begin
        rt_fwd = rt_data;
        if (rt != '0 && ex_mem_regwrite && ex_mem_rd == rt) begin
            rt_fwd = ex_mem_result;
        end else if (rt != '0 && mem_wb_regwrite && mem_wb_rd == rt) begin
            rt_fwd = mem_wb_result;
        end
    end
`else
    logic unused_fwd_inputs;

    assign unused_fwd_inputs = ^{rs, rt, ex_mem_regwrite, ex_mem_rd, ex_mem_result,
                                 mem_wb_regwrite, mem_wb_rd, mem_wb_result};

    always_comb begin
        rs_fwd = rs_data;
        rt_fwd = rt_data;
    end
`endif

    always_comb begin
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        sd_d    = sd_q;
        ctrl_d  = ctrl_q;
        if (flush) begin
            valid_d = 1'b0;
            a_d     = '0;
            b_d     = '0;
            sd_d    = '0;
            ctrl_d  = ALU_ADD;
        end else if (!stall) begin
            valid_d = in_valid;
            a_d     = rs_fwd;
            b_d     = alu_src ? imm : rt_fwd;
            sd_d    = rt_fwd;
            ctrl_d  = ctrl_dec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sd_q    <= '0;
            ctrl_q  <= ALU_ADD;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sd_q    <= sd_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign out_valid   = valid_q;
    assign A           = a_q;
    assign B           = b_q;
    assign store_data  = sd_q;
    assign ALU_Control = ctrl_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage; expectations follow ALU_ISSUE_FWD_EN when defined.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, stall, flush, alu_src;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [4:0]  rs, rt, ex_mem_rd, mem_wb_rd;
    logic [31:0] rs_data, rt_data, imm, ex_mem_result, mem_wb_result;
    logic        ex_mem_regwrite, mem_wb_regwrite;
    logic        out_valid;
    logic [31:0] A, B, store_data;
    logic [2:0]  ALU_Control;

    typedef struct {
        logic        v;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic [2:0]  c;
        bit          chk;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_e;
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_issue_stage #(.DW(32), .RW(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .alu_op(alu_op), .funct(funct), .alu_src(alu_src), .rs(rs), .rt(rt),
        .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
        .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_rd(ex_mem_rd), .ex_mem_result(ex_mem_result),
        .mem_wb_regwrite(mem_wb_regwrite), .mem_wb_rd(mem_wb_rd), .mem_wb_result(mem_wb_result),
        .out_valid(out_valid), .A(A), .B(B), .ALU_Control(ALU_Control), .store_data(store_data)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] ctrl_m(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b00) return 3'd2;
        if (op == 2'b01) return 3'd6;
        if (op == 2'b11) return 3'd7;
        case (f)
            6'b100010: return 3'd6;
            6'b100100: return 3'd0;
            6'b100101: return 3'd1;
            6'b101010: return 3'd7;
            default:   return 3'd2;
        endcase
    endfunction

    function automatic logic [31:0] fwd_m(input logic [4:0] idx, input logic [31:0] rf);
`ifdef ALU_ISSUE_FWD_EN
        if (idx != 5'd0 && ex_mem_regwrite && ex_mem_rd == idx) return ex_mem_result;
        if (idx != 5'd0 && mem_wb_regwrite && mem_wb_rd == idx) return mem_wb_result;
`endif
        return rf;
    endfunction

    // Computes what the next edge should register, queues it, then advances past that edge.
    task automatic cycle();
        exp_t n;
        logic [31:0] rtf;
        if (rst || flush) begin
            n.v = 1'b0; n.a = '0; n.b = '0; n.sd = '0; n.c = 3'd2; n.chk = 1'b1;
        end else if (stall) begin
            n = last_e;
        end else begin
            rtf   = fwd_m(rt, rt_data);
            n.v   = in_valid;
            n.a   = fwd_m(rs, rs_data);
            n.b   = alu_src ? imm : rtf;
            n.sd  = rtf;
            n.c   = ctrl_m(alu_op, funct);
            n.chk = in_valid;
        end
        last_e = n;
        exp_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; in_valid = 0; stall = 0; flush = 0; alu_src = 0;
        alu_op = 2'b00; funct = '0; rs = '0; rt = '0;
        rs_data = '0; rt_data = '0; imm = '0;
        ex_mem_regwrite = 0; ex_mem_rd = '0; ex_mem_result = '0;
        mem_wb_regwrite = 0; mem_wb_rd = '0; mem_wb_result = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        cycle();
        e = exp_q.pop_front();
        n_checks++;
        if ({out_valid, A, B, ALU_Control, store_data} !== {e.v, e.a, e.b, e.c, e.sd}) begin
            n_fail++;
            $display("FAIL reset_init: got v=%0b A=%h B=%h C=%0d SD=%h want v=%0b A=%h B=%h C=%0d SD=%h",
                     out_valid, A, B, ALU_Control, store_data, e.v, e.a, e.b, e.c, e.sd);
        end
        rst = 0; in_valid = 1; alu_op = 2'b01; rs = 5'd3; rt = 5'd4;
        rs_data = 32'hAAAA_0001; rt_data = 32'hBBBB_0002;
        cycle();
        e = exp_q.pop_front();
        n_checks++;
        if ({out_valid, A, B, ALU_Control, store_data} !== {e.v, e.a, e.b, e.c, e.sd}) begin
            n_fail++;
            $display("FAIL reset_load: got v=%0b A=%h C=%0d want v=%0b A=%h C=%0d",
                     out_valid, A, ALU_Control, e.v, e.a, e.c);
        end
        stall = 1;
        cycle();
        void'(exp_q.pop_front());
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            e = exp_q.pop_front();
            n_checks++;
            if ({out_valid, A, B, ALU_Control, store_data} !== {1'b0, 32'h0, 32'h0, 3'd2, 32'h0}) begin
                n_fail++;
                $display("FAIL reset_mid_stall[%0d]: got v=%0b A=%h B=%h C=%0d SD=%h want 0/0/0/2/0",
                         i, out_valid, A, B, ALU_Control, store_data);
            end
        end
        rst = 0; stall = 0;
    endtask

    task automatic test_decode();
        logic [5:0] fl [5] = '{6'b100100, 6'b100101, 6'b101010, 6'b100010, 6'b111111};
        logic [2:0] cl [5] = '{3'd0, 3'd1, 3'd7, 3'd6, 3'd2};
        logic [1:0] ol [3] = '{2'b00, 2'b01, 2'b11};
        logic [2:0] oc [3] = '{3'd2, 3'd6, 3'd7};
        idle_inputs();
        in_valid = 1; alu_op = 2'b10;
        for (int i = 0; i < 5; i++) begin
            funct = fl[i];
            cycle();
            e = exp_q.pop_front();
            n_checks++;
            if (ALU_Control !== cl[i] || e.c !== cl[i] || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL rtype_funct_%b: got C=%0d v=%0b want C=%0d v=1",
                         fl[i], ALU_Control, out_valid, cl[i]);
            end
        end
        funct = 6'b100100;
        for (int i = 0; i < 3; i++) begin
            alu_op = ol[i];
            cycle();
            e = exp_q.pop_front();
            n_checks++;
            if (ALU_Control !== oc[i]) begin
                n_fail++;
                $display("FAIL aluop_%b: got C=%0d want C=%0d", ol[i], ALU_Control, oc[i]);
            end
        end
    endtask

    task automatic test_fwd_priority();
        logic [31:0] want [3];
`ifdef ALU_ISSUE_FWD_EN
        want = '{32'h11, 32'h22, 32'h33};
`else
        want = '{32'h33, 32'h33, 32'h33};
`endif
        idle_inputs();
        in_valid = 1; rs = 5'd5; rs_data = 32'h33;
        ex_mem_regwrite = 1; ex_mem_rd = 5'd5; ex_mem_result = 32'h11;
        mem_wb_regwrite = 1; mem_wb_rd = 5'd5; mem_wb_result = 32'h22;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) ex_mem_regwrite = 0;
            if (i == 2) begin
                rs = 5'd0; ex_mem_regwrite = 1; ex_mem_rd = 5'd0; mem_wb_rd = 5'd0;
            end
            cycle();
            e = exp_q.pop_front();
            n_checks++;
            if (A !== want[i] || e.a !== want[i]) begin
                n_fail++;
                $display("FAIL fwd_priority[%0d]: got A=%h want A=%h", i, A, want[i]);
            end
        end
    endtask

    task automatic test_imm_path();
        logic [31:0] want_sd;
`ifdef ALU_ISSUE_FWD_EN
        want_sd = 32'h44;
`else
        want_sd = 32'h55;
`endif
        idle_inputs();
        in_valid = 1; alu_src = 1; imm = 32'hFFFF_FFF0;
        rt = 5'd7; rt_data = 32'h55;
        ex_mem_regwrite = 1; ex_mem_rd = 5'd7; ex_mem_result = 32'h44;
        cycle();
        e = exp_q.pop_front();
        n_checks++;
        if (B !== 32'hFFFF_FFF0 || store_data !== want_sd) begin
            n_fail++;
            $display("FAIL imm_path: got B=%h SD=%h want B=fffffff0 SD=%h", B, store_data, want_sd);
        end
    endtask

    task automatic test_stall_flush();
        idle_inputs();
        in_valid = 1; rs = 5'd1; rs_data = 32'h10; rt = 5'd2; rt_data = 32'h20; alu_op = 2'b01;
        cycle();
        e = exp_q.pop_front();
        n_checks++;
        if (A !== 32'h10 || B !== 32'h20 || ALU_Control !== 3'd6 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_load: got A=%h B=%h C=%0d v=%0b want 10/20/6/1", A, B, ALU_Control, out_valid);
        end
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            rs_data = 32'h100 + i; rt_data = 32'h200 + i; alu_op = 2'b11; in_valid = i[0];
            cycle();
            e = exp_q.pop_front();
            n_checks++;
            if ({out_valid, A, B, ALU_Control, store_data} !== {1'b1, 32'h10, 32'h20, 3'd6, 32'h20}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got v=%0b A=%h B=%h C=%0d SD=%h want 1/10/20/6/20",
                         i, out_valid, A, B, ALU_Control, store_data);
            end
        end
        flush = 1;
        cycle();
        e = exp_q.pop_front();
        n_checks++;
        if ({out_valid, A, B, ALU_Control, store_data} !== {1'b0, 32'h0, 32'h0, 3'd2, 32'h0}) begin
            n_fail++;
            $display("FAIL flush_over_stall: got v=%0b A=%h B=%h C=%0d SD=%h want 0/0/0/2/0",
                     out_valid, A, B, ALU_Control, store_data);
        end
        stall = 0; flush = 0; in_valid = 1; rs_data = 32'h77; rt_data = 32'h88; alu_op = 2'b00;
        cycle();
        e = exp_q.pop_front();
        n_checks++;
        if ({out_valid, A, B, ALU_Control} !== {1'b1, 32'h77, 32'h88, 3'd2}) begin
            n_fail++;
            $display("FAIL release: got v=%0b A=%h B=%h C=%0d want 1/77/88/2", out_valid, A, B, ALU_Control);
        end
        in_valid = 0;
        cycle();
        e = exp_q.pop_front();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL invalid_load: got v=%0b want v=0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            in_valid = $urandom_range(0, 1); stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0); alu_src = $urandom_range(0, 1);
            alu_op = $urandom_range(0, 3); funct = {3'b100, 3'($urandom_range(0, 7))};
            rs = $urandom_range(0, 3); rt = $urandom_range(0, 3);
            rs_data = $urandom; rt_data = $urandom; imm = $urandom;
            ex_mem_regwrite = $urandom_range(0, 1); ex_mem_rd = $urandom_range(0, 3); ex_mem_result = $urandom;
            mem_wb_regwrite = $urandom_range(0, 1); mem_wb_rd = $urandom_range(0, 3); mem_wb_result = $urandom;
            cycle();
            e = exp_q.pop_front();
            n_checks++;
            if (out_valid !== e.v) begin
                n_fail++;
                $display("FAIL b2b_valid[%0d]: got v=%0b want v=%0b", i, out_valid, e.v);
            end
            if (e.chk) begin
                n_checks++;
                if ({A, B, ALU_Control, store_data} !== {e.a, e.b, e.c, e.sd}) begin
                    n_fail++;
                    $display("FAIL b2b_data[%0d]: got A=%h B=%h C=%0d SD=%h want A=%h B=%h C=%0d SD=%h",
                             i, A, B, ALU_Control, store_data, e.a, e.b, e.c, e.sd);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        last_e = '{v: 1'b0, a: '0, b: '0, sd: '0, c: 3'd2, chk: 1'b1};
        #2;
        test_reset();
        test_decode();
        test_fwd_priority();
        test_imm_path();
        test_stall_flush();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
